// File: rtl/coin_pkg.sv
// Shared types and geometry for the spinning coin sprite controller.
package coin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SPIN    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_GONE    = 2'd3
    } coin_state_e;

    localparam int SPRITE_W      = 20;
    localparam int SPRITE_H      = 20;
    localparam int NUM_SPIN      = 4;
    localparam int COLLECT_STEPS = 8;
    localparam int RISE_PX       = 2;

endpackage

// File: rtl/sprite_addr_gen.sv
// Combinational box test and sprite ROM address for the coin, with the
// coin's top edge lifted by the collect rise offset.
module sprite_addr_gen
    import coin_pkg::*;
(
    input  logic [9:0] i_draw_x,
    input  logic [9:0] i_draw_y,
    input  logic [9:0] i_coin_x,
    input  logic [9:0] i_coin_y,
    input  logic [5:0] i_rise,
    output logic       o_inside,
    output logic [8:0] o_addr
);

    localparam logic signed [10:0] W_S = 11'(SPRITE_W);
    localparam logic signed [10:0] H_S = 11'(SPRITE_H);
    localparam logic [8:0]         W_9 = 9'(SPRITE_W);

    logic signed [10:0] w_dx;
    logic signed [10:0] w_top;
    logic signed [10:0] w_dy;

    // Signed 11-bit math lets a top edge above row 0 clip instead of wrapping.
    assign w_dx  = $signed({1'b0, i_draw_x}) - $signed({1'b0, i_coin_x});
    assign w_top = $signed({1'b0, i_coin_y}) - $signed({5'b0, i_rise});
    assign w_dy  = $signed({1'b0, i_draw_y}) - w_top;

    assign o_inside = !w_dx[10] && (w_dx < W_S) && !w_dy[10] && (w_dy < H_S);
    assign o_addr   = o_inside ? (9'(w_dy[4:0]) * W_9 + 9'(w_dx[4:0])) : 9'd0;

endmodule

// File: rtl/coin_spin_ctrl.sv
// Coin animation controller: spins through four images, then on collect
// rises and spins faster for eight steps before disappearing.
module coin_spin_ctrl
    import coin_pkg::*;
#(
    parameter int HOLD_FRAMES  = 8,
    parameter int COLLECT_HOLD = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_start,
    input  logic       enable,
    input  logic       collect,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] CoinX,
    input  logic [9:0] CoinY,
    output logic [1:0] frame_sel,
    output logic [8:0] read_address,
    output logic       pixel_valid,
    output logic       done
);

    localparam logic [3:0] SPIN_LAST = 4'(HOLD_FRAMES - 1);
    localparam logic [3:0] COLL_LAST = 4'(COLLECT_HOLD - 1);
    localparam logic [2:0] STEP_LAST = 3'(COLLECT_STEPS - 1);
    localparam logic [5:0] RISE_INC  = 6'(RISE_PX);

    coin_state_e r_state, w_state_nxt;
    logic [3:0]  r_hold, w_hold_nxt;
    logic [2:0]  r_step, w_step_nxt;
    logic [5:0]  r_rise, w_rise_nxt;
    logic [1:0]  r_sel, w_sel_nxt;
    logic        w_done_nxt;
    logic        r_done;
    logic        r_pv;
    logic [8:0]  r_addr;
    logic        w_inside;
    logic [8:0]  w_addr;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_step  <= '0;
            r_rise  <= '0;
            r_sel   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_step  <= w_step_nxt;
            r_rise  <= w_rise_nxt;
            r_sel   <= w_sel_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_step_nxt  = r_step;
        w_rise_nxt  = r_rise;
        w_sel_nxt   = r_sel;
        w_done_nxt  = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_hold_nxt  = '0;
            w_step_nxt  = '0;
            w_rise_nxt  = '0;
            w_sel_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_SPIN;
                ST_SPIN: begin
                    // collect takes priority over a coincident frame_start
                    if (collect) begin
                        w_state_nxt = ST_COLLECT;
                        w_hold_nxt  = '0;
                        w_step_nxt  = '0;
                        w_rise_nxt  = '0;
                    end else if (frame_start) begin
                        if (r_hold == SPIN_LAST) begin
                            w_hold_nxt = '0;
                            w_sel_nxt  = r_sel + 2'd1;
                        end else begin
                            w_hold_nxt = r_hold + 4'd1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (frame_start) begin
                        if (r_hold == COLL_LAST) begin
                            w_hold_nxt = '0;
                            w_sel_nxt  = r_sel + 2'd1;
                            w_step_nxt = r_step + 3'd1;
                            w_rise_nxt = r_rise + RISE_INC;
                            if (r_step == STEP_LAST) begin
                                w_state_nxt = ST_GONE;
                                w_done_nxt  = 1'b1;
                            end
                        end else begin
                            w_hold_nxt = r_hold + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    sprite_addr_gen u_addr (
        .i_draw_x (DrawX),
        .i_draw_y (DrawY),
        .i_coin_x (CoinX),
        .i_coin_y (CoinY),
        .i_rise   (r_rise),
        .o_inside (w_inside),
        .o_addr   (w_addr)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pv   <= 1'b0;
            r_addr <= '0;
        end else begin
            r_pv   <= w_inside && (r_state != ST_GONE);
            r_addr <= w_addr;
        end
    end

    assign frame_sel    = r_sel;
    assign read_address = r_addr;
    assign pixel_valid  = r_pv;
    assign done         = r_done;

endmodule

// File: tb/tb_coin_spin_ctrl.sv
// Self-checking bench for coin_spin_ctrl: directed scenarios followed by
// randomized traffic, all checked against a frame-counting reference model.
module tb_coin_spin_ctrl;

    localparam int HF = 8;
    localparam int CH = 2;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       enable = 1'b0;
    logic       collect = 1'b0;
    logic [9:0] DrawX = '0, DrawY = '0, CoinX = '0, CoinY = '0;
    logic [1:0] frame_sel;
    logic [8:0] read_address;
    logic       pixel_valid;
    logic       done;

    coin_spin_ctrl #(.HOLD_FRAMES(HF), .COLLECT_HOLD(CH)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .enable(enable), .collect(collect),
        .DrawX(DrawX), .DrawY(DrawY), .CoinX(CoinX), .CoinY(CoinY),
        .frame_sel(frame_sel), .read_address(read_address),
        .pixel_valid(pixel_valid), .done(done)
    );

    always #5 Clk = ~Clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 spin, 2 collect, 3 gone; animation
    // position derived from frame pulse counts by integer division.
    int m_mode = 0, m_spin = 0, m_coll = 0, m_base = 0;
    int e_pv = 0, e_ra = 0, e_done = 0;
    int done_cnt = 0;

    function automatic int m_sel();
        case (m_mode)
            1: return (m_spin / HF) % 4;
            2: return (m_base + m_coll / CH) % 4;
            3: return (m_base + 8) % 4;
            default: return 0;
        endcase
    endfunction

    function automatic int m_rise();
        case (m_mode)
            2: return 2 * (m_coll / CH);
            3: return 16;
            default: return 0;
        endcase
    endfunction

    function automatic int clampc(input int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_spin = 0; m_coll = 0; m_base = 0;
        e_pv = 0; e_ra = 0; e_done = 0;
    endtask

    task automatic model_edge();
        int dx, dy;
        bit in;
        dx = int'(DrawX) - int'(CoinX);
        dy = int'(DrawY) - (int'(CoinY) - m_rise());
        in = (dx >= 0) && (dx < 20) && (dy >= 0) && (dy < 20);
        e_ra = in ? dy * 20 + dx : 0;
        e_pv = (in && m_mode != 3) ? 1 : 0;
        e_done = 0;
        if (!enable) begin
            m_mode = 0; m_spin = 0; m_coll = 0; m_base = 0;
        end else begin
            case (m_mode)
                0: begin m_mode = 1; m_spin = 0; end
                1: begin
                    if (collect) begin
                        m_base = m_sel(); m_mode = 2; m_coll = 0;
                    end else if (frame_start) m_spin++;
                end
                2: if (frame_start) begin
                    m_coll++;
                    if (m_coll / CH == 8) begin m_mode = 3; e_done = 1; end
                end
                default: ;
            endcase
        end
    endtask

    // Called at a falling edge; drives inputs, steps one rising edge, checks.
    task automatic step(input bit en, input bit fs, input bit col,
                        input int dxv, input int dyv, input int cx, input int cy);
        enable = en; frame_start = fs; collect = col;
        DrawX = 10'(clampc(dxv)); DrawY = 10'(clampc(dyv));
        CoinX = 10'(clampc(cx));  CoinY = 10'(clampc(cy));
        @(posedge Clk);
        model_edge();
        #1;
        chk("frame_sel", frame_sel, m_sel());
        chk("pixel_valid", pixel_valid, e_pv);
        chk("read_address", read_address, e_ra);
        chk("done", done, e_done);
        if (done === 1'b1) done_cnt++;
        @(negedge Clk);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            step(1, 1, 0, 119, 69, 100, 50);
            step(1, 0, 0, 119, 69, 100, 50);
        end
    endtask

    initial begin
        #1;
        chk("rst_sel", frame_sel, 0);
        chk("rst_pv", pixel_valid, 0);
        chk("rst_ra", read_address, 0);
        chk("rst_done", done, 0);
        @(negedge Clk); @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();

        // spin cadence with box corner probe
        step(1, 0, 0, 119, 69, 100, 50);
        step(1, 0, 0, 119, 69, 100, 50);
        chk("corner_pv", pixel_valid, 1);
        chk("corner_ra", read_address, 399);
        step(1, 0, 0, 120, 69, 100, 50);
        chk("edge_pv", pixel_valid, 0);
        chk("edge_ra", read_address, 0);
        for (int p = 1; p <= 40; p++) begin
            pulses(1);
            if (p % 8 == 0) chk("spin_sel", frame_sel, (p / 8) % 4);
        end

        // collect coincident with the advancing frame_start
        pulses(7);
        step(1, 1, 1, 119, 69, 100, 50);
        chk("coll_sel_hold", frame_sel, 1);
        pulses(1);
        chk("coll_hold_clr", frame_sel, 1);
        pulses(1);
        chk("coll_adv1", frame_sel, 2);

        // async reset at collect step 5
        pulses(8);
        done_cnt = 0;
        Reset_n = 1'b0;
        #1;
        chk("arst_sel", frame_sel, 0);
        chk("arst_pv", pixel_valid, 0);
        chk("arst_ra", read_address, 0);
        chk("arst_done", done, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        chk("arst_no_done", done_cnt, 0);
        step(1, 0, 0, 119, 69, 100, 50);
        pulses(8);
        chk("restart_sel", frame_sel, 1);

        // full collect sequence
        done_cnt = 0;
        step(1, 0, 1, 119, 69, 100, 50);
        pulses(16);
        chk("done_once", done_cnt, 1);
        step(1, 0, 0, 103, 34, 100, 50);
        step(1, 0, 0, 103, 34, 100, 50);
        chk("rise_row0_ra", read_address, 3);
        chk("gone_pv", pixel_valid, 0);
        step(1, 0, 0, 103, 33, 100, 50);
        step(1, 0, 0, 103, 33, 100, 50);
        chk("rise_above_ra", read_address, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 103, 40, 100, 50);
        chk("gone_frozen", frame_sel, 1);

        // enable low beats collect in spin
        step(0, 0, 0, 100, 50, 100, 50);
        step(1, 0, 0, 100, 50, 100, 50);
        step(0, 1, 1, 100, 50, 100, 50);
        step(1, 0, 0, 100, 50, 100, 50);
        pulses(8);
        chk("en_over_coll", frame_sel, 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int cx, cy, r;
            cx = $urandom_range(0, 1023);
            cy = $urandom_range(0, 1023);
            if ($urandom_range(0, 3) == 0) cy = $urandom_range(0, 20);
            r = m_rise();
            step($urandom_range(0, 99) < 98, $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 4,
                 cx + $urandom_range(0, 25) - 3,
                 cy - r + $urandom_range(0, 25) - 3, cx, cy);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
